// File: rtl/qpu_exu_commit_if.sv
// Commit-stage bus of the QPU execution unit: ALU commit handshake, the
// flush request towards the fetch unit, and retire status/performance
// counters. The master side is the environment (ALU, IFU, CSR logic); the
// slave side is qpu_exu_commit.

`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif

interface qpu_exu_commit_if #(
    parameter int PC_W = `QPU_PC_SIZE,
    parameter int XLEN = `QPU_XLEN
) ();
    // commit input from the ALU
    logic            cmt_i_valid;
    logic            cmt_i_ready;
    logic [PC_W-1:0] cmt_i_pc;
    logic [XLEN-1:0] cmt_i_imm;
    logic            cmt_i_bjp;
    logic            cmt_i_bjp_prdt;
    logic            cmt_i_bjp_rslv;

    // flush towards the fetch unit
    logic            pipe_flush_req;
    logic            pipe_flush_ack;
    logic [PC_W-1:0] pipe_flush_pc;

    // retire status and counters
    logic            cmt_o_retire;
    logic            cmt_o_mispred;
    logic            cnt_clr;
    logic [31:0]     cnt_retired;
    logic [31:0]     cnt_mispred;

    modport master (
        output cmt_i_valid, cmt_i_pc, cmt_i_imm, cmt_i_bjp, cmt_i_bjp_prdt,
               cmt_i_bjp_rslv, pipe_flush_ack, cnt_clr,
        input  cmt_i_ready, pipe_flush_req, pipe_flush_pc, cmt_o_retire,
               cmt_o_mispred, cnt_retired, cnt_mispred
    );

    modport slave (
        input  cmt_i_valid, cmt_i_pc, cmt_i_imm, cmt_i_bjp, cmt_i_bjp_prdt,
               cmt_i_bjp_rslv, pipe_flush_ack, cnt_clr,
        output cmt_i_ready, pipe_flush_req, pipe_flush_pc, cmt_o_retire,
               cmt_o_mispred, cnt_retired, cnt_mispred
    );
endinterface

// File: rtl/qpu_exu_commit.sv
// QPU execution-unit commit stage.
// Retires every instruction handed over by the ALU, resolves branch
// predictions and, on a mispredict, raises a held flush request with the
// corrected fetch PC until the fetch unit acknowledges it.
// Optional feature macro: QPU_CMT_PERF_CNT_EN enables the 32-bit retired and
// mispredict counters; without it the counter outputs are tied to zero.
// XLEN must be at least PC_W; only the low PC_W bits of the offset are used.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for commits; flush request low
// S_FLUSH | mispredict outstanding; commits stalled, flush request held

`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif

module qpu_exu_commit #(
    parameter int PC_W = `QPU_PC_SIZE,
    parameter int XLEN = `QPU_XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    qpu_exu_commit_if.slave       cmt_if
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            ready_c;
    logic            flush_req_c;
    logic            accept_c;
    logic            mispred_c;
    logic            flush_load_c;
    logic [PC_W-1:0] target_c;
    logic [PC_W-1:0] flush_pc_q, flush_pc_d;
    logic            retire_q, retire_d;
    logic            mispred_q, mispred_d;

    // Branch outcome check and corrected fetch target (wraps modulo 2^PC_W).
    always_comb begin
        mispred_c = cmt_if.cmt_i_bjp & (cmt_if.cmt_i_bjp_prdt != cmt_if.cmt_i_bjp_rslv);
        if (cmt_if.cmt_i_bjp_rslv) begin
            target_c = cmt_if.cmt_i_pc + cmt_if.cmt_i_imm[PC_W-1:0];
        end else begin
            target_c = cmt_if.cmt_i_pc + PC_W'(4);
        end
    end

    // Next state and state-decoded handshake outputs; ready and flush request
    // depend only on state so there is no valid-to-ready path.
    always_comb begin
        state_d      = state_q;
        ready_c      = 1'b0;
        flush_req_c  = 1'b0;
        accept_c     = 1'b0;
        flush_load_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c  = 1'b1;
                accept_c = cmt_if.cmt_i_valid;
                if (accept_c && mispred_c) begin
                    flush_load_c = 1'b1;
                    state_d      = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_req_c = 1'b1;
                if (cmt_if.pipe_flush_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the registered datapath: the flush PC only changes on an
    // accepted mispredict, pulses mark each accept for exactly one cycle.
    always_comb begin
        flush_pc_d = flush_load_c ? target_c : flush_pc_q;
        retire_d   = accept_c;
        mispred_d  = accept_c & mispred_c;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush target and retire/mispredict pulse registers; reset discards any
    // pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pc_q <= '0;
            retire_q   <= 1'b0;
            mispred_q  <= 1'b0;
        end else begin
            flush_pc_q <= flush_pc_d;
            retire_q   <= retire_d;
            mispred_q  <= mispred_d;
        end
    end

    assign cmt_if.cmt_i_ready    = ready_c;
    assign cmt_if.pipe_flush_req = flush_req_c;
    assign cmt_if.pipe_flush_pc  = flush_pc_q;
    assign cmt_if.cmt_o_retire   = retire_q;
    assign cmt_if.cmt_o_mispred  = mispred_q;

    // Offset bits above the PC width have no effect on the target.
    if (XLEN > PC_W) begin : g_imm_hi
        logic unused_imm_hi;
        assign unused_imm_hi = |cmt_if.cmt_i_imm[XLEN-1:PC_W];
    end

`ifdef QPU_CMT_PERF_CNT_EN
    logic [31:0] cnt_retired_q, cnt_retired_d;
    logic [31:0] cnt_mispred_q, cnt_mispred_d;

    // Counters follow the registered pulses and wrap; clear beats increment.
    always_comb begin
        cnt_retired_d = cnt_retired_q;
        cnt_mispred_d = cnt_mispred_q;
        if (cmt_if.cnt_clr) begin
            cnt_retired_d = '0;
            cnt_mispred_d = '0;
        end else begin
            if (retire_q) begin
                cnt_retired_d = cnt_retired_q + 32'd1;
            end
            if (mispred_q) begin
                cnt_mispred_d = cnt_mispred_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_retired_q <= '0;
            cnt_mispred_q <= '0;
        end else begin
            cnt_retired_q <= cnt_retired_d;
            cnt_mispred_q <= cnt_mispred_d;
        end
    end

    assign cmt_if.cnt_retired = cnt_retired_q;
    assign cmt_if.cnt_mispred = cnt_mispred_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr     = cmt_if.cnt_clr;
    assign cmt_if.cnt_retired = '0;
    assign cmt_if.cnt_mispred = '0;
`endif

endmodule

// File: doc/qpu_exu_commit.md
# qpu_exu_commit

Commit stage of the QPU execution unit, directly downstream of `QPU_exu_alu`. It consumes the ALU commit interface (`cmt_o_*`) and retires every instruction. It resolves branch predictions and, on a mispredict, issues a held pipeline-flush request with the corrected PC to the fetch unit. Optional performance counters track retired and mispredicted instructions.

## Interface

Parameters:
- `PC_W`, default `` `QPU_PC_SIZE ``: program-counter width.
- `XLEN`, default `` `QPU_XLEN ``: immediate width. Must satisfy `XLEN` ≥ `PC_W`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  reset.
- Commit input:
  - `cmt_i_valid`  in  1  commit valid, from ALU `cmt_o_valid`.
  - `cmt_i_ready`  out  1  commit ready, to ALU `cmt_o_ready`.
  - `cmt_i_pc`  in  PC_W  PC of the committing instruction.
  - `cmt_i_imm`  in  XLEN  branch offset (byte, signed).
  - `cmt_i_bjp`  in  1  instruction is a branch.
  - `cmt_i_bjp_prdt`  in  1  predicted taken.
  - `cmt_i_bjp_rslv`  in  1  resolved taken.
- Flush to fetch:
  - `pipe_flush_req`  out  1  flush request to IFU.
  - `pipe_flush_ack`  in  1  IFU accepts the flush.
  - `pipe_flush_pc`  out  PC_W  corrected fetch PC.
- Status and counters:
  - `cmt_o_retire`  out  1  one-cycle pulse per retired instruction.
  - `cmt_o_mispred`  out  1  one-cycle pulse per mispredicted branch.
  - `cnt_clr`  in  1  synchronous clear of the counters.
  - `cnt_retired`  out  32  retired-instruction count.
  - `cnt_mispred`  out  32  mispredict count.

## Operation

- FSM states:
  - IDLE: `cmt_i_ready`=1.
  - FLUSH: `cmt_i_ready`=0 and `pipe_flush_req`=1.
- Accept condition: `cmt_i_valid & cmt_i_ready`.
- Mispredict = `cmt_i_bjp & (cmt_i_bjp_prdt != cmt_i_bjp_rslv)`.
- On an accepted mispredict, register the target:
  - If `rslv`=1: `pipe_flush_pc` = `cmt_i_pc + cmt_i_imm[PC_W-1:0]`, modulo 2^PC_W, with no overflow flag.
  - If `rslv`=0: `pipe_flush_pc` = `cmt_i_pc + 4`, modulo 2^PC_W.
  - The FSM moves to FLUSH.
- Correctly predicted branches and non-branches retire only. There is no flush and `pipe_flush_pc` is unchanged.
- In FLUSH, `pipe_flush_req` and `pipe_flush_pc` hold stable until `pipe_flush_ack`=1. The FSM then returns to IDLE on the next edge.
- `pipe_flush_ack` is ignored in IDLE.
- `cmt_o_retire` is registered high for one cycle after every accept. `cmt_o_mispred` does the same for every accepted mispredict.
- Reset values: `pipe_flush_req`=0, `pipe_flush_pc`=0, `cmt_o_retire`=0, `cmt_o_mispred`=0, counters=0, state=IDLE.
  - `cmt_i_ready` is 1 during reset (combinational from state).
- Reset during FLUSH: the request drops at that edge and the pending target is discarded.

## Timing

- Accept at edge N → `cmt_o_retire`/`cmt_o_mispred`/`pipe_flush_req`/`pipe_flush_pc` valid after edge N+1.
- `cmt_i_ready` falls in the cycle after a mispredict accept. At most one flush is outstanding.
- Ack in the first FLUSH cycle: the FSM is in IDLE after the following edge, and `cmt_i_ready`=1 in that cycle. Minimum back-to-back mispredict spacing is 2 cycles.
- Back-to-back non-mispredict commits are accepted every cycle.
- No combinational path from `cmt_i_valid` to `cmt_i_ready`. The only path into `pipe_flush_req` is from state.

## Configuration

- `QPU_CMT_PERF_CNT_EN` defined: counters are active.
  - `cnt_retired` increments on each `cmt_o_retire` pulse. `cnt_mispred` increments on each `cmt_o_mispred` pulse.
  - Both wrap from 0xFFFFFFFF to 0.
  - `cnt_clr` zeroes both at the next edge. A clear in the same cycle as an increment wins (result 0).
- `QPU_CMT_PERF_CNT_EN` undefined: no counter registers exist. `cnt_retired`=`cnt_mispred`=0 constantly and `cnt_clr` is ignored. All other behaviour is identical.

## Test plan

- Non-branch stream: PC 0x00, 0x04, 0x08, valid every cycle.
  - Required: 3 `cmt_o_retire` pulses, `pipe_flush_req` stays 0, and `cnt_retired`=3 (macro on).
- Taken mispredict: pc=0x40, imm=0xFFFFFFF0, bjp=1, prdt=0, rslv=1.
  - Required: `pipe_flush_req`=1 and `pipe_flush_pc`=0x30 next cycle, `cmt_i_ready`=0.
  - Hold ack=0 for 3 cycles → request and PC stay stable. Ack=1 → IDLE one edge later.
- Not-taken mispredict: pc=0xFFFFFFFC, prdt=1, rslv=0.
  - Required: `pipe_flush_pc`=0x00000000 (wrap) and `cnt_mispred`=1.
- Correct prediction: bjp=1, prdt=rslv=1, pc=0x10, imm=0x20.
  - Required: retire pulse only, no flush, `pipe_flush_pc` unchanged.
- Reset in FLUSH: after the taken-mispredict case, assert `rst` 1 cycle before ack.
  - Required: `pipe_flush_req`=0, `pipe_flush_pc`=0 and `cmt_i_ready`=1 after the edge. A late ack is ignored.
- Counter edge: with the macro on, preload `cnt_retired` to 0xFFFFFFFF by forcing, then retire 1 → 0. Assert `cnt_clr` together with a retire → 0.
